// File: rtl/svo_tmds_hdmi_enc.sv
// svo_tmds_hdmi_enc: three-channel TMDS encoder with optional HDMI
// video preamble / guard band, fixed 12-cycle latency.
`timescale 1ns/1ps
module svo_tmds_hdmi_enc #(
  parameter int IN_BITS   = 8,
  parameter int HDMI_MODE = 1,
  parameter int SYNC_INV  = 0
) (
  input  logic               clk_pixel,
  input  logic               resetn,
  input  logic               de,
  input  logic               hsync,
  input  logic               vsync,
  input  logic [IN_BITS-1:0] r,
  input  logic [IN_BITS-1:0] g,
  input  logic [IN_BITS-1:0] b,
  output logic [9:0]         tmds_ch0,
  output logic [9:0]         tmds_ch1,
  output logic [9:0]         tmds_ch2,
  output logic               short_blank
);

  localparam logic [9:0] CTL0 = 10'b1101010100;
  localparam logic [9:0] CTL1 = 10'b0010101011;
  localparam logic [9:0] CTL2 = 10'b0101010100;
  localparam logic [9:0] CTL3 = 10'b1010101011;
  localparam logic [9:0] GB_02 = 10'b1011001100;
  localparam logic [9:0] GB_1 = 10'b0100110011;
  localparam int DLY = 10;
  localparam logic SINV = (SYNC_INV != 0);
  localparam logic HDMI = (HDMI_MODE != 0);

  typedef struct packed {
    logic       de;
    logic       vs;
    logic       hs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  typedef enum logic [1:0] {
    S_CTRL,
    S_PRE,
    S_GUARD,
    S_VIDEO
  } st_t;

  function automatic logic [3:0] ones8(
    input logic [7:0] v
  );
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 8; i++)
      s = s + {3'b000, v[i]};
    return s;
  endfunction

  function automatic logic [8:0] tm(
    input logic [7:0] d
  );
    logic [8:0] q;
    logic [3:0] n;
    logic       xn;
    n = ones8(d);
    xn = (n > 4'd4) ||
         ((n == 4'd4) && !d[0]);
    q[0] = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = q[i-1] ^ d[i] ^ xn;
    q[8] = ~xn;
    return q;
  endfunction

  // returns {new_cnt[4:0], word[9:0]}
  function automatic logic [14:0] dc_bal(
    input logic        [8:0] qm,
    input logic signed [4:0] cnt
  );
    logic        [3:0] n1;
    logic signed [4:0] diff;
    logic signed [4:0] nc;
    logic        [9:0] w;
    n1 = ones8(qm[7:0]);
    diff = {n1, 1'b0} - 5'd8;
    if (cnt == 5'sd0 || diff == 5'sd0) begin
      w = {~qm[8], qm[8],
           qm[8] ? qm[7:0] : ~qm[7:0]};
      nc = qm[8] ? cnt + diff : cnt - diff;
    end else if (cnt[4] == diff[4]) begin
      w = {1'b1, qm[8], ~qm[7:0]};
      nc = cnt - diff +
           (qm[8] ? 5'sd2 : 5'sd0);
    end else begin
      w = {1'b0, qm[8], qm[7:0]};
      nc = cnt + diff -
           (qm[8] ? 5'sd0 : 5'sd2);
    end
    return {nc, w};
  endfunction

  function automatic logic [9:0] ctl(
    input logic [1:0] c
  );
    logic [9:0] w;
    unique case (c)
      2'b00: w = CTL0;
      2'b01: w = CTL1;
      2'b10: w = CTL2;
      default: w = CTL3;
    endcase
    return w;
  endfunction

  logic [7:0] r8;
  logic [7:0] g8;
  logic [7:0] b8;

  if (IN_BITS == 8) begin : g_pass
    assign r8 = r;
    assign g8 = g;
    assign b8 = b;
  end else begin : g_exp
    assign r8 = {r, r[IN_BITS-1 -: 8-IN_BITS]};
    assign g8 = {g, g[IN_BITS-1 -: 8-IN_BITS]};
    assign b8 = {b, b[IN_BITS-1 -: 8-IN_BITS]};
  end

  pix_t       in_pix;
  pix_t       dly_q [DLY];
  pix_t       dly_d [DLY];
  pix_t       tap;
  logic [3:0] blank_q;
  logic [3:0] blank_d;
  logic       rise;
  logic       start;

  st_t        st_q;
  st_t        st_d;
  logic [2:0] ctr_q;
  logic [2:0] ctr_d;
  logic       sb_q;
  logic       sb_d;

  logic [8:0] qm_q [3];
  logic [8:0] qm_d [3];
  logic [1:0] syn_q;
  logic [1:0] syn_d;

  logic        [9:0] ch_q  [3];
  logic        [9:0] ch_d  [3];
  logic signed [4:0] cnt_q [3];
  logic signed [4:0] cnt_d [3];

  // Input capture, delay-line shift and blank-run count
  always_comb begin
    in_pix = {de, vsync ^ SINV,
              hsync ^ SINV, r8, g8, b8};
    dly_d[0] = in_pix;
    for (int i = 1; i < DLY; i++)
      dly_d[i] = dly_q[i-1];
    tap = dly_q[DLY-1];
    blank_d = de ? 4'd0 :
              (blank_q == 4'hF) ? 4'hF :
              blank_q + 4'd1;
    rise = de & ~dly_q[0].de;
    start = HDMI & rise &
            (blank_q >= 4'd12);
  end

  // Lookahead delay line and blank-run counter
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      dly_q <= '{default: '0};
      blank_q <= 4'd0;
    end else begin
      dly_q <= dly_d;
      blank_q <= blank_d;
    end
  end

  // Next-state logic; state is the mode of the stage-1 word
  always_comb begin
    st_d = st_q;
    ctr_d = ctr_q;
    sb_d = HDMI & rise &
           (blank_q < 4'd12);
    unique case (st_q)
      S_PRE: begin
        ctr_d = ctr_q + 3'd1;
        if (ctr_q == 3'd7) begin
          st_d = S_GUARD;
          ctr_d = 3'd0;
        end
      end
      S_GUARD: begin
        ctr_d = ctr_q + 3'd1;
        if (ctr_q == 3'd1) begin
          st_d = tap.de ? S_VIDEO : S_CTRL;
          ctr_d = 3'd0;
        end
      end
      default: begin
        if (start) begin
          st_d = S_PRE;
          ctr_d = 3'd0;
        end else begin
          st_d = tap.de ? S_VIDEO : S_CTRL;
        end
      end
    endcase
  end

  // Line-timing FSM with registered short-blank pulse
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      st_q <= S_CTRL;
      ctr_q <= 3'd0;
      sb_q <= 1'b0;
    end else begin
      st_q <= st_d;
      ctr_q <= ctr_d;
      sb_q <= sb_d;
    end
  end

  // Stage-1 transition minimisation
  always_comb begin
    qm_d[0] = tm(tap.b);
    qm_d[1] = tm(tap.g);
    qm_d[2] = tm(tap.r);
    syn_d = {tap.vs, tap.hs};
  end

  // Stage-1 pipeline registers
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      qm_q <= '{default: '0};
      syn_q <= 2'b00;
    end else begin
      qm_q <= qm_d;
      syn_q <= syn_d;
    end
  end

  // Stage-2 word selection and DC balance
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      ch_d[c] = CTL0;
      cnt_d[c] = 5'sd0;
    end
    unique case (st_q)
      S_VIDEO: begin
        for (int c = 0; c < 3; c++)
          {cnt_d[c], ch_d[c]} =
            dc_bal(qm_q[c], cnt_q[c]);
      end
      S_PRE: begin
        ch_d[0] = ctl(syn_q);
        ch_d[1] = CTL1;
      end
      S_GUARD: begin
        ch_d[0] = GB_02;
        ch_d[1] = GB_1;
        ch_d[2] = GB_02;
      end
      default: ch_d[0] = ctl(syn_q);
    endcase
  end

  // Stage-2 output words and running disparity
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      ch_q <= '{default: CTL0};
      cnt_q <= '{default: '0};
    end else begin
      ch_q <= ch_d;
      cnt_q <= cnt_d;
    end
  end

  assign tmds_ch0 = ch_q[0];
  assign tmds_ch1 = ch_q[1];
  assign tmds_ch2 = ch_q[2];
  assign short_blank = sb_q;

endmodule

// File: tb/tb_svo_tmds_hdmi_enc.sv
// tb_svo_tmds_hdmi_enc: random + directed bench for the TMDS encoder,
// HDMI/8-bit instance and DVI/6-bit/inverted-sync instance.
`timescale 1ns/1ps
module tb_svo_tmds_hdmi_enc;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] GB02 = 10'b1011001100;
  localparam logic [9:0] GB1 = 10'b0100110011;
  localparam int HMAX = 8192;

  logic clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  logic       resetn = 1'b0;
  logic       de = 1'b0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic [5:0] ra = '0, ga = '0, ba = '0;
  logic [9:0] m0, m1, m2, a0, a1, a2;
  logic       msb, asb;

  svo_tmds_hdmi_enc #(
    .IN_BITS(8), .HDMI_MODE(1), .SYNC_INV(0)
  ) u_hdmi (
    .clk_pixel(clk_pixel), .resetn(resetn),
    .de(de), .hsync(hsync), .vsync(vsync),
    .r(r), .g(g), .b(b),
    .tmds_ch0(m0), .tmds_ch1(m1),
    .tmds_ch2(m2), .short_blank(msb)
  );

  svo_tmds_hdmi_enc #(
    .IN_BITS(6), .HDMI_MODE(0), .SYNC_INV(1)
  ) u_dvi (
    .clk_pixel(clk_pixel), .resetn(resetn),
    .de(de), .hsync(hsync), .vsync(vsync),
    .r(ra), .g(ga), .b(ba),
    .tmds_ch0(a0), .tmds_ch1(a1),
    .tmds_ch2(a2), .short_blank(asb)
  );

  int checks = 0;
  int failures = 0;
  int k = 0;
  int blank = 0;
  int cnt_m [2][3];
  int t0, t1, nsb;

  bit hde [HMAX], hhs [HMAX], hvs [HMAX];
  bit hst [HMAX], hsh [HMAX];
  logic [7:0] hr [HMAX], hg [HMAX], hb [HMAX];
  logic [9:0] lm0 [HMAX], lm1 [HMAX];
  logic [9:0] lm2 [HMAX], la0 [HMAX];
  bit lsb [HMAX];

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ctl(int c);
    case (c)
      0: return C00;
      1: return C01;
      2: return C10;
      default: return C11;
    endcase
  endfunction

  // colour as the design should see it, widened to 8 bits
  function automatic logic [7:0] ex(
    logic [7:0] v, int bits
  );
    int x;
    if (bits == 8) return v;
    x = int'(v) >> (8 - bits);
    return 8'((x << (8 - bits)) |
              (x >> (2 * bits - 8)));
  endfunction

  // DVI 1.0 encoding with integer disparity
  task automatic enc_ref(
    input logic [7:0] d,
    input int cin,
    output logic [9:0] w,
    output int cout
  );
    logic [8:0] q;
    int n, n1, n0, x;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    x = (n > 4 || (n == 4 && d[0] == 1'b0)) ? 1 : 0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = x ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = (x == 0);
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(q[i]);
    n0 = 8 - n1;
    if (cin == 0 || n1 == n0) begin
      if (q[8]) begin
        w = {2'b01, q[7:0]};
        cout = cin + n1 - n0;
      end else begin
        w = {2'b10, ~q[7:0]};
        cout = cin + n0 - n1;
      end
    end else if ((cin > 0 && n1 > n0) ||
                 (cin < 0 && n0 > n1)) begin
      w = {1'b1, q[8], ~q[7:0]};
      cout = cin + 2 * int'(q[8]) + n0 - n1;
    end else begin
      w = {1'b0, q[8], q[7:0]};
      cout = cin - 2 * (1 - int'(q[8])) + n1 - n0;
    end
  endtask

  task automatic check_cycle();
    int p, sraw, sc, mode, t, cout;
    bit dp;
    logic [9:0] e [3];
    logic [9:0] got [3];
    logic [7:0] d8 [3];
    p = k - 12;
    dp = (p >= 0) ? hde[p] : 1'b0;
    sraw = (p >= 0) ?
           (int'(hvs[p]) * 2 + int'(hhs[p])) : 0;
    lm0[k] = m0; lm1[k] = m1;
    lm2[k] = m2; la0[k] = a0;
    lsb[k] = msb;
    for (int u = 0; u < 2; u++) begin
      sc = (p >= 0 && u == 1) ? (sraw ^ 3) : sraw;
      mode = 0;
      if (u == 0)
        for (int off = 2; off <= 11; off++) begin
          t = k - off;
          if (t >= 0 && hst[t])
            mode = (off <= 9) ? 1 : 2;
        end
      if (mode == 0 && dp) mode = 3;
      e[0] = ctl(sc); e[1] = C00; e[2] = C00;
      if (mode == 1) e[1] = C01;
      if (mode == 2) begin
        e[0] = GB02; e[1] = GB1; e[2] = GB02;
      end
      if (mode == 3) begin
        d8[0] = ex(hb[p], u == 0 ? 8 : 6);
        d8[1] = ex(hg[p], u == 0 ? 8 : 6);
        d8[2] = ex(hr[p], u == 0 ? 8 : 6);
        for (int c = 0; c < 3; c++) begin
          enc_ref(d8[c], cnt_m[u][c], e[c], cout);
          cnt_m[u][c] = cout;
        end
      end else begin
        for (int c = 0; c < 3; c++) cnt_m[u][c] = 0;
      end
      got[0] = (u == 0) ? m0 : a0;
      got[1] = (u == 0) ? m1 : a1;
      got[2] = (u == 0) ? m2 : a2;
      for (int c = 0; c < 3; c++)
        chk($sformatf("u%0d_ch%0d_k%0d", u, c, k),
            32'(got[c]), 32'(e[c]));
      chk($sformatf("u%0d_sb_k%0d", u, k),
          32'((u == 0) ? msb : asb),
          32'(u == 0 && hsh[k-1]));
    end
  endtask

  task automatic drive(
    input bit d, input bit h, input bit v,
    input logic [7:0] rr,
    input logic [7:0] gg,
    input logic [7:0] bb
  );
    bit rise;
    de = d; hsync = h; vsync = v;
    r = rr; g = gg; b = bb;
    ra = rr[7:2]; ga = gg[7:2]; ba = bb[7:2];
    rise = d && (k == 0 || !hde[k-1]);
    hde[k] = d; hhs[k] = h; hvs[k] = v;
    hr[k] = rr; hg[k] = gg; hb[k] = bb;
    hst[k] = rise && blank >= 12;
    hsh[k] = rise && blank < 12;
    blank = d ? 0 : (blank < 15 ? blank + 1 : 15);
    @(posedge clk_pixel);
    #1;
    k++;
    check_cycle();
  endtask

  task automatic blanks(int n, bit h, bit v);
    repeat (n)
      drive(1'b0, h, v, 8'($urandom),
            8'($urandom), 8'($urandom));
  endtask

  task automatic pixels(int n);
    repeat (n)
      drive(1'b1, 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic rst_checks(string tag);
    chk({tag, "_m0"}, 32'(m0), 32'(C00));
    chk({tag, "_m1"}, 32'(m1), 32'(C00));
    chk({tag, "_m2"}, 32'(m2), 32'(C00));
    chk({tag, "_msb"}, 32'(msb), 32'd0);
    chk({tag, "_a0"}, 32'(a0), 32'(C00));
    chk({tag, "_a2"}, 32'(a2), 32'(C00));
  endtask

  task automatic do_reset(int hold);
    resetn = 1'b0;
    #1;
    rst_checks("rst_now");
    repeat (hold) begin
      @(posedge clk_pixel);
      #1;
      rst_checks("rst_hold");
    end
    k = 0;
    blank = 0;
    for (int u = 0; u < 2; u++)
      for (int c = 0; c < 3; c++) cnt_m[u][c] = 0;
    resetn = 1'b1;
  endtask

  initial begin
    @(posedge clk_pixel);
    #1;
    do_reset(2);

    blanks(20, 1'b1, 1'b0);
    t0 = k;
    repeat (16) drive(1'b1, 1'b0, 1'b0,
                      8'hFC, 8'h80, 8'h00);
    blanks(5, 1'b0, 1'b1);
    t1 = k;
    pixels(10);
    blanks(20, 1'b0, 1'b0);

    chk("dvi_b0_w0", 32'(la0[t0+12]), 32'h100);
    chk("dvi_b0_w1", 32'(la0[t0+13]), 32'h3FF);
    chk("dvi_b0_w2", 32'(la0[t0+14]), 32'h100);
    chk("pre_before", 32'(lm1[t0+1]), 32'(C00));
    chk("pre_first", 32'(lm1[t0+2]), 32'(C01));
    chk("pre_last", 32'(lm1[t0+9]), 32'(C01));
    chk("pre_ch2", 32'(lm2[t0+5]), 32'(C00));
    chk("guard_ch0", 32'(lm0[t0+10]), 32'(GB02));
    chk("guard_ch1", 32'(lm1[t0+11]), 32'(GB1));
    chk("first_pix", 32'(lm1[t0+12]),
        32'(10'b0110000000));
    chk("sync_inv", 32'(la0[t0+11]), 32'(C10));
    chk("sync_main", 32'(lm0[t0+1]), 32'(C01));
    chk("short_pulse", 32'(lsb[t1+1]), 32'd1);
    nsb = 0;
    for (int i = t0; i <= t1 + 14; i++)
      nsb += int'(lsb[i]);
    chk("short_count", 32'(nsb), 32'd1);
    chk("short_noguard", 32'(lm1[t1+10]), 32'(C00));
    chk("short_nopre", 32'(lm1[t1+11]), 32'(C00));

    blanks(15, 1'b0, 1'b0);
    pixels(20);
    do_reset(2);
    blanks(4, 1'b1, 1'b1);
    pixels(8);
    blanks(13, 1'b0, 1'b1);
    pixels(6);

    for (int ln = 0; ln < 60; ln++) begin
      blanks($urandom_range(1, 18),
             1'($urandom), 1'($urandom));
      pixels($urandom_range(1, 40));
      if (ln == 30) do_reset($urandom_range(1, 3));
    end
    blanks(16, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
